// File: rtl/run_ctrl.sv
// Front-panel run/stop/step controller: debounced buttons drive a four-state
// FSM that gates the machine clock generator on machine-cycle boundaries.
module run_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_btn,
  input  logic              stop_btn,
  input  logic              step_btn,
  input  logic              cycle_clk,
  input  logic              hlt_instr,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              halt,
  output logic [1:0]        mode,
  output logic              step_ack,
  output logic              bp_hit
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_RUNNING = 2'b01,
    ST_STEP    = 2'b10,
    ST_HALTED  = 2'b11
  } mode_e;

  localparam int              CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Button order in all 3-bit vectors: {step, stop, run}
  logic [2:0] btn_raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] acc;
  logic [2:0] acc_prev_q;
  logic [2:0] press;
  logic       run_p, stop_p, step_p;

  assign btn_raw = {step_btn, stop_btn, run_btn};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      acc_prev_q <= 3'b000;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      acc_prev_q <= acc;
    end
  end

  // The accepted level flips only on the DEB_CYCLES-th consecutive disagreeing clk.
  for (genvar b = 0; b < 3; b++) begin : g_deb
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_q, acc_d;

    always_comb begin
      cnt_d = '0;
      acc_d = acc_q;
      if (sync2_q[b] != acc_q) begin
        if (cnt_q == CNT_LAST) begin
          acc_d = sync2_q[b];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
        acc_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        acc_q <= acc_d;
      end
    end

    assign acc[b] = acc_q;
  end

  assign press  = acc & ~acc_prev_q;
  assign stop_p = press[1];
  assign step_p = press[2] & ~press[1];
  assign run_p  = press[0] & ~press[1] & ~press[2];

  // Phase tracks the clock generator: 0 is the cycle phase, 2 the last phase.
  logic [1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q + 2'd1;
    if (cycle_clk) begin
      phase_d = 2'd1;
    end else if (phase_q == 2'd2) begin
      phase_d = 2'd0;
    end
  end

  mode_e mode_q, mode_d;
  logic  halt_q, halt_d;
  logic  ack_q, ack_d;
  logic  bp_hit_q, bp_hit_d;
  logic  seen_q, seen_d;
  logic  bp_match;

  assign bp_match = bp_en && (pc == bp_addr);

  always_comb begin
    mode_d   = mode_q;
    halt_d   = halt_q;
    ack_d    = 1'b0;
    bp_hit_d = bp_hit_q;
    seen_d   = seen_q;
    unique case (mode_q)
      ST_STOPPED: begin
        if (run_p) begin
          mode_d = ST_RUNNING;
        end else if (step_p) begin
          mode_d = ST_STEP;
        end
      end
      ST_RUNNING: begin
        if (stop_p) begin
          mode_d = ST_STOPPED;
        end else if (cycle_clk && (hlt_instr || bp_match)) begin
          mode_d   = ST_HALTED;
          bp_hit_d = bp_match;
        end
      end
      ST_STEP: begin
        if (stop_p) begin
          mode_d = ST_STOPPED;
        end else if (seen_q && (phase_q == 2'd2)) begin
          mode_d = ST_STOPPED;
          ack_d  = 1'b1;
        end else if (cycle_clk && !halt_q) begin
          seen_d = 1'b1;
        end
      end
      ST_HALTED: begin
        if (stop_p) begin
          mode_d = ST_STOPPED;
        end else if (step_p) begin
          mode_d   = ST_STEP;
          bp_hit_d = 1'b0;
        end else if (run_p) begin
          mode_d   = ST_RUNNING;
          bp_hit_d = 1'b0;
        end
      end
      default: mode_d = ST_STOPPED;
    endcase
    if (mode_d != ST_STEP) begin
      seen_d = 1'b0;
    end
    // halt follows the post-edge mode so a finishing step re-halts on the same edge
    if (phase_q == 2'd2) begin
      halt_d = (mode_d == ST_STOPPED) || (mode_d == ST_HALTED);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= ST_STOPPED;
      halt_q   <= 1'b1;
      ack_q    <= 1'b0;
      bp_hit_q <= 1'b0;
      seen_q   <= 1'b0;
      phase_q  <= 2'd0;
    end else begin
      mode_q   <= mode_d;
      halt_q   <= halt_d;
      ack_q    <= ack_d;
      bp_hit_q <= bp_hit_d;
      seen_q   <= seen_d;
      phase_q  <= phase_d;
    end
  end

  assign mode     = mode_q;
  assign halt     = halt_q;
  assign step_ack = ack_q;
  assign bp_hit   = bp_hit_q;

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, 16: consecutive clocks a synchronized button level must hold before it is accepted.
REQ-002 Parameter ADDR_W, 8: width of pc and bp_addr.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 run_btn, stop_btn, step_btn  in  1 each  raw asynchronous front-panel buttons, active-high.
REQ-006 cycle_clk  in  1  cycle-phase enable from the clock generator; high for one clk per machine cycle, low while halted.
REQ-007 hlt_instr  in  1  decoded HLT instruction, valid when cycle_clk=1.
REQ-008 pc  in  ADDR_W  current program counter, valid when cycle_clk=1.
REQ-009 bp_en  in  1  breakpoint enable; bp_addr  in  ADDR_W  breakpoint address.
REQ-010 halt  out  1  registered halt to the clock generator; 1 gates all phase enables.
REQ-011 mode  out  2  FSM state: 00 STOPPED, 01 RUNNING, 10 STEP, 11 HALTED.
REQ-012 step_ack  out  1  one-clk pulse when a single step completes.
REQ-013 bp_hit  out  1  sticky flag: HALTED was entered by breakpoint match.

Function
REQ-014 Each button SHALL pass a 2-FF synchronizer, then a debouncer: accepted level changes only after synced value differs from it for DEB_CYCLES consecutive clks; any agreeing clk clears the count.
REQ-015 A rising edge of an accepted level SHALL produce a one-clk press pulse (run_p, stop_p, step_p); releases produce nothing.
REQ-016 Same-clk presses SHALL be prioritized stop_p > step_p > run_p; lower-priority pulses that clk are discarded.
REQ-017 Internal phase counter phase_q SHALL count 0,1,2,0,... every clk, forced to 1 on the clk following any cycle_clk=1 (i.e. phase_q=0 during the cycle phase).
REQ-018 halt SHALL update only at rising edges where phase_q=2, loading 1 if mode is STOPPED or HALTED, else 0; between such edges halt holds.
REQ-019 STOPPED: run_p -> RUNNING; step_p -> STEP; stop_p ignored.
REQ-020 RUNNING: stop_p -> STOPPED; cycle_clk=1 and hlt_instr=1 -> HALTED; cycle_clk=1, bp_en=1, pc==bp_addr -> HALTED and bp_hit<=1; hlt and breakpoint together -> HALTED with bp_hit=1.
REQ-021 STEP: stop_p -> STOPPED without step_ack; after halt has fallen, the first phase_q=2 edge following an observed cycle_clk -> STOPPED, halt<=1 on that same edge, step_ack=1 for that clk; run_p/step_p ignored.
REQ-022 STEP SHALL execute exactly one machine cycle (one cycle_clk), breakpoint and HLT checks not applied.
REQ-023 HALTED: run_p -> RUNNING and bp_hit<=0; step_p -> STEP and bp_hit<=0; stop_p -> STOPPED, bp_hit held.
REQ-024 A stop request SHALL take effect on halt only after the current machine cycle completes (next phase_q=2 edge); no partial cycle is cut off.
REQ-025 mode SHALL be the registered FSM state; transitions take effect the clk after the triggering input.

Reset
REQ-026 reset=0 SHALL immediately force mode=00, halt=1, step_ack=0, bp_hit=0, phase_q=0, synchronizers, accepted levels and debounce counters to 0, regardless of state (including mid-step).
REQ-027 After reset release, no press pulse SHALL be generated for a button already held until it is accepted per REQ-014.

Verification
REQ-028 Reset, hold run_btn 20 clks -> run_p once, mode=01, halt falls at next phase_q=2 edge, stays 0.
REQ-029 RUNNING, hlt_instr=1 with cycle_clk -> mode=11 next clk, halt=1 at following phase_q=2 edge, bp_hit=0.
REQ-030 RUNNING, bp_en=1, bp_addr=8'h2A, pc=8'h2A on cycle_clk -> mode=11, bp_hit=1; then run press -> mode=01, bp_hit=0.
REQ-031 STOPPED, step press -> exactly one cycle_clk observed, step_ack one pulse, mode=00, halt=1.
REQ-032 run_btn toggling every 5 clks for 100 clks -> no press pulse, mode unchanged; stop+run same clk -> stop wins.
REQ-033 reset asserted during STEP with halt=0 -> halt=1 and mode=00 without waiting for clk.
